// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: datapath widths, FSM state
// encoding and the DIV/REM result select used by the EX stage.
package seq_divider_pkg;

   // Datapath width of the CPU and its data bus.
   localparam int CPU_WIDTH = 32;
   localparam int DATABUS   = 32;

   // Divider FSM states.
   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   // EX-stage select between the quotient (DIV) and the remainder (REM).
   typedef enum logic [0:0] {
      SEL_DIV = 1'b0,
      SEL_REM = 1'b1
   } div_sel_e;

   // Picks the architectural result for a DIV or REM instruction.
   function automatic logic [DATABUS-1:0] div_result_sel(
      input div_sel_e           sel,
      input logic [DATABUS-1:0] quot,
      input logic [DATABUS-1:0] rem
   );
      return (sel == SEL_REM) ? rem : quot;
   endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, then subtract the divisor if it fits.
module div_step
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = CPU_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dvd_msb,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] next_rem,
   output logic             q_bit
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;

   // Compare at WIDTH+1 bits: the shifted remainder can reach 2*dvs-1, which
   // does not fit in WIDTH bits. When the divisor fits, the true difference is
   // below dvs, so the low WIDTH bits of the wrapped subtraction are exact.
   always_comb begin
      shifted  = {rem, dvd_msb};
      q_bit    = (shifted >= {1'b0, dvs});
      diff     = shifted[WIDTH-1:0] - dvs;
      next_rem = q_bit ? diff : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with a start/busy/done handshake. One quotient
// bit is produced per cycle; signed operation works on magnitudes and applies
// sign fixups when the results are registered.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = CPU_WIDTH,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   div_state_e       state_reg;
   logic [CNT_W-1:0] count_reg;

   // dvd_reg shifts out dividend bits at the top while quotient bits enter at
   // the bottom, so after WIDTH steps it holds the unsigned quotient.
   logic [WIDTH-1:0] dvd_reg;
   logic [WIDTH-1:0] dvs_reg;
   logic [WIDTH-1:0] rem_reg;
   logic             neg_q_reg;
   logic             neg_r_reg;

   logic             ready_reg;
   logic             busy_reg;
   logic             done_reg;
   logic             dbz_reg;
   logic [WIDTH-1:0] quot_reg;
   logic [WIDTH-1:0] remd_reg;

   logic             dividend_neg;
   logic             divisor_neg;
   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_mag;

   logic [WIDTH-1:0] step_rem;
   logic             step_q;
   logic [WIDTH-1:0] final_quot;

   // Operand magnitudes and signs; MIN maps onto itself, which is the correct
   // unsigned magnitude 2^(WIDTH-1).
   always_comb begin
      dividend_neg = is_signed & dividend[WIDTH-1];
      divisor_neg  = is_signed & divisor[WIDTH-1];
      dividend_mag = dividend_neg ? -dividend : dividend;
      divisor_mag  = divisor_neg  ? -divisor  : divisor;
   end

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem      (rem_reg),
      .dvd_msb  (dvd_reg[WIDTH-1]),
      .dvs      (dvs_reg),
      .next_rem (step_rem),
      .q_bit    (step_q)
   );

   // Quotient after the current step, used both for shifting and on the last step.
   always_comb begin
      final_quot = {dvd_reg[WIDTH-2:0], step_q};
   end

   // Control FSM, iteration datapath and registered results.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= DIV_IDLE;
         count_reg <= '0;
         dvd_reg   <= '0;
         dvs_reg   <= '0;
         rem_reg   <= '0;
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
         ready_reg <= 1'b1;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         dbz_reg   <= 1'b0;
         quot_reg  <= '0;
         remd_reg  <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            // IDLE and DONE both accept a new operation.
            DIV_IDLE, DIV_DONE: begin
               if (start) begin
                  neg_q_reg <= dividend_neg ^ divisor_neg;
                  neg_r_reg <= dividend_neg;
                  dvd_reg   <= dividend_mag;
                  dvs_reg   <= divisor_mag;
                  rem_reg   <= '0;
                  if (divisor == '0) begin
                     // Division by zero resolves immediately with the raw dividend.
                     state_reg <= DIV_DONE;
                     count_reg <= '0;
                     ready_reg <= 1'b1;
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                     dbz_reg   <= 1'b1;
                     quot_reg  <= '1;
                     remd_reg  <= dividend;
                  end else begin
                     state_reg <= DIV_CALC;
                     count_reg <= CNT_W'(WIDTH);
                     ready_reg <= 1'b0;
                     busy_reg  <= 1'b1;
                  end
               end else begin
                  state_reg <= DIV_IDLE;
                  ready_reg <= 1'b1;
                  busy_reg  <= 1'b0;
               end
            end

            // One restoring step per cycle; start is ignored here.
            DIV_CALC: begin
               dvd_reg   <= final_quot;
               rem_reg   <= step_rem;
               count_reg <= count_reg - CNT_W'(1);
               if (count_reg == CNT_W'(1)) begin
                  state_reg <= DIV_DONE;
                  ready_reg <= 1'b1;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  dbz_reg   <= 1'b0;
                  quot_reg  <= neg_q_reg ? -final_quot : final_quot;
                  remd_reg  <= neg_r_reg ? -step_rem   : step_rem;
               end
            end

            default: begin
               state_reg <= DIV_IDLE;
               ready_reg <= 1'b1;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign ready       = ready_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign div_by_zero = dbz_reg;
   assign quotient    = quot_reg;
   assign remainder   = remd_reg;

endmodule
